// File: rtl/fetch_realigner.sv
// fetch_realigner: splits 32-bit fetch words into up to two aligned (possibly compressed) instructions
// Optional feature macro: FETCH_REALIGNER_RVC_EN (defined: compressed handling; undefined: one
// 32-bit instruction per fetch word in slot 0).
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              drop stored half-word and output register
//   fetch_valid_i/_ready_o, fetch_data_i, fetch_addr_i, fetch_ex_i   fetch side
//   valid_o, instr_o, addr_o, ex_o, out_ready_i                      instruction queue side
// VLEN defaults to 64, the riscv::VLEN value of the RV64 core this block serves.
module fetch_realigner #(
   parameter int unsigned VLEN = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic                      fetch_valid_i,
   output logic                      fetch_ready_o,
   input  logic [31:0]               fetch_data_i,
   input  logic [VLEN-1:0]           fetch_addr_i,
   input  logic                      fetch_ex_i,
   output logic [1:0]                valid_o,
   output logic [1:0][31:0]          instr_o,
   output logic [1:0][VLEN-1:0]      addr_o,
   output logic                      ex_o,
   input  logic                      out_ready_i
);
   logic                 w_acc;
   logic [1:0]           w_valid;
   logic [1:0][31:0]     w_instr;
   logic [1:0][VLEN-1:0] w_addr;
   assign fetch_ready_o = (valid_o == 2'b00) | out_ready_i;
   assign w_acc = fetch_valid_i & fetch_ready_o;
`ifdef FETCH_REALIGNER_RVC_EN
   typedef enum logic {EMPTY, PEND} state_t;
   state_t          r_state, w_state_n;
   logic [15:0]     r_stash, w_stash_n;
   logic [VLEN-1:0] r_stash_addr, w_stash_addr_n;
   logic [15:0]     w_lo, w_hi;
   logic            w_lo_c, w_hi_c, w_use_hi, w_hi_s0;
   logic [VLEN-1:0] w_hi_addr;
   assign w_lo = fetch_data_i[15:0];
   assign w_hi = fetch_data_i[31:16];
   assign w_lo_c = w_lo[1:0] != 2'b11;
   assign w_hi_c = w_hi[1:0] != 2'b11;
   // The upper half-word always sits at addr|2, so no carry can occur here.
   assign w_hi_addr = {fetch_addr_i[VLEN-1:2], 1'b1, fetch_addr_i[0]};
   // Upper half goes to slot 0 only when it is the sole useful half of a fresh word.
   assign w_hi_s0 = (r_state == EMPTY) & fetch_addr_i[1];
   assign w_use_hi = (r_state == PEND) | fetch_addr_i[1] | w_lo_c;
   always_comb begin
      w_state_n = EMPTY;
      w_stash_n = r_stash;
      w_stash_addr_n = r_stash_addr;
      w_valid = 2'b01;
      w_instr[0] = fetch_data_i;
      w_addr[0] = (r_state == PEND) ? r_stash_addr : fetch_addr_i;
      w_instr[1] = {16'h0, w_hi};
      w_addr[1] = w_hi_addr;
      if (!fetch_ex_i) begin
         if (r_state == PEND)
            w_instr[0] = {w_lo, r_stash};
         else if (fetch_addr_i[1])
            w_instr[0] = {16'h0, w_hi};
         else if (w_lo_c)
            w_instr[0] = {16'h0, w_lo};
         if (w_use_hi && w_hi_c)
            w_valid = w_hi_s0 ? 2'b01 : 2'b11;
         else if (w_use_hi) begin
            w_state_n = PEND;
            w_stash_n = w_hi;
            w_stash_addr_n = w_hi_addr;
            w_valid = w_hi_s0 ? 2'b00 : 2'b01;
         end
      end
   end
`else
   assign w_valid = 2'b01;
   assign w_instr = {32'h0, fetch_data_i};
   assign w_addr = {{VLEN{1'b0}}, fetch_addr_i};
`endif
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o <= 2'b00;
         instr_o <= '0;
         addr_o <= '0;
         ex_o <= 1'b0;
`ifdef FETCH_REALIGNER_RVC_EN
         r_state <= EMPTY;
         r_stash <= '0;
         r_stash_addr <= '0;
`endif
      end else if (flush_i) begin
         valid_o <= 2'b00;
         ex_o <= 1'b0;
`ifdef FETCH_REALIGNER_RVC_EN
         r_state <= EMPTY;
         r_stash <= '0;
         r_stash_addr <= '0;
`endif
      end else if (w_acc) begin
         valid_o <= w_valid;
         instr_o <= w_instr;
         addr_o <= w_addr;
         ex_o <= fetch_ex_i;
`ifdef FETCH_REALIGNER_RVC_EN
         r_state <= w_state_n;
         r_stash <= w_stash_n;
         r_stash_addr <= w_stash_addr_n;
`endif
      end else if (out_ready_i) begin
         valid_o <= 2'b00;
         ex_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fetch_realigner.sv
// tb_fetch_realigner: scoreboard bench for fetch_realigner (directed vectors, both macro builds)
module tb_fetch_realigner;
   localparam int VLEN = 64;
   logic clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
   logic fetch_valid_i = 1'b0, fetch_ex_i = 1'b0, out_ready_i = 1'b1;
   logic fetch_ready_o, ex_o;
   logic [31:0] fetch_data_i = '0;
   logic [VLEN-1:0] fetch_addr_i = '0;
   logic [1:0] valid_o;
   logic [1:0][31:0] instr_o;
   logic [1:0][VLEN-1:0] addr_o;
   typedef struct {
      logic [1:0] v;
      logic [31:0] i0, i1;
      logic [VLEN-1:0] a0, a1;
      logic ex;
   } exp_t;
   exp_t q[$];
   int n_pass = 0, n_tot = 0;
   fetch_realigner #(.VLEN(VLEN)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
      .fetch_data_i(fetch_data_i), .fetch_addr_i(fetch_addr_i), .fetch_ex_i(fetch_ex_i),
      .valid_o(valid_o), .instr_o(instr_o), .addr_o(addr_o), .ex_o(ex_o),
      .out_ready_i(out_ready_i)
   );
   always #5 clk_i = ~clk_i;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   // Monitor: every negedge where an output is offered and taken is one delivered transaction.
   always @(negedge clk_i) begin
      if (!rst_i && valid_o != 2'b00 && out_ready_i) begin
         n_tot++;
         if (q.size() == 0)
            $display("FAIL unexpected_out: got v=%b i0=%h a0=%h, required no output", valid_o, instr_o[0], addr_o[0]);
         else begin
            exp_t e;
            e = q.pop_front();
            if (valid_o === e.v && ex_o === e.ex && instr_o[0] === e.i0 && addr_o[0] === e.a0 &&
                (!e.v[1] || (instr_o[1] === e.i1 && addr_o[1] === e.a1)))
               n_pass++;
            else
               $display("FAIL out: got v=%b ex=%b i0=%h a0=%h i1=%h a1=%h, required v=%b ex=%b i0=%h a0=%h i1=%h a1=%h",
                        valid_o, ex_o, instr_o[0], addr_o[0], instr_o[1], addr_o[1],
                        e.v, e.ex, e.i0, e.a0, e.i1, e.a1);
         end
      end
   end
   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      n_tot++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h", nm, act, req);
   endtask
   task automatic xp(logic [1:0] v, logic [31:0] i0, logic [63:0] a0,
                     logic [31:0] i1, logic [63:0] a1, logic ex);
      exp_t e;
      e.v = v; e.i0 = i0; e.a0 = a0; e.i1 = i1; e.a1 = a1; e.ex = ex;
      q.push_back(e);
   endtask
   task automatic send(logic [31:0] d, logic [63:0] a, logic ex);
      logic ok;
      ok = 1'b0;
      fetch_valid_i = 1'b1; fetch_data_i = d; fetch_addr_i = a; fetch_ex_i = ex;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk_i);
         ok = fetch_ready_o;
      end
      if (!ok) begin
         n_tot++;
         $display("FAIL send_timeout: got fetch_ready_o=0, required 1 within 50 cycles");
      end
      @(posedge clk_i); #1;
      fetch_valid_i = 1'b0; fetch_ex_i = 1'b0;
   endtask
   initial begin
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_valid", 64'(valid_o), 64'h0);
      chk("rst_ex", 64'(ex_o), 64'h0);
      chk("rst_instr", 64'(instr_o), 64'h0);
      chk("rst_addr0", addr_o[0], 64'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("idle_ready", 64'(fetch_ready_o), 64'h1);
      @(posedge clk_i); #1;
`ifdef FETCH_REALIGNER_RVC_EN
      xp(2'b11, 32'h1, 'h1000, 32'h1, 'h1002, 0);
      send(32'h00010001, 'h1000, 0);
      xp(2'b01, 32'h1, 'h1000, 0, 0, 0);
      send(32'h00130001, 'h1000, 0);
      xp(2'b11, 32'h00000013, 'h1002, 32'h1, 'h1006, 0);
      send(32'h00010000, 'h1004, 0);
      xp(2'b01, 32'h00A00093, 'h1008, 0, 0, 0);
      send(32'h00A00093, 'h1008, 0);
      xp(2'b01, 32'h4505, 'h100A, 0, 0, 0);
      send(32'h4505FFFF, 'h100A, 0);
      send(32'h00930000, 'h100E, 0);
      xp(2'b11, 32'h00A00093, 'h100E, 32'h4111, 'h1012, 0);
      send(32'h411100A0, 'h1010, 0);
      xp(2'b01, 32'h1, 'h1020, 0, 0, 0);
      send(32'h00930001, 'h1020, 0);
      xp(2'b01, 32'h00A00093, 'h1022, 0, 0, 0);
      send(32'h009300A0, 'h1024, 0);
      xp(2'b11, 32'h00A00093, 'h1026, 32'h1, 'h102A, 0);
      send(32'h000100A0, 'h1028, 0);
      xp(2'b01, 32'h1, 'h1000, 0, 0, 0);
      send(32'h00130001, 'h1000, 0);
      xp(2'b01, 32'hDEADBEEF, 'h1002, 0, 0, 1);
      send(32'hDEADBEEF, 'h1004, 1);
      xp(2'b11, 32'h1, 'h1008, 32'h1, 'h100A, 0);
      send(32'h00010001, 'h1008, 0);
      xp(2'b11, 32'h1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      send(32'h00010001, 64'hFFFF_FFFF_FFFF_FFFC, 0);
      xp(2'b11, 32'h1, 'h1100, 32'h1, 'h1102, 0);
`else
      xp(2'b01, 32'h00010001, 'h1002, 0, 0, 0);
      send(32'h00010001, 'h1002, 0);
      xp(2'b01, 32'h00130001, 'h1000, 0, 0, 0);
      send(32'h00130001, 'h1000, 0);
      xp(2'b01, 32'hDEADBEEF, 'h1004, 0, 0, 1);
      send(32'hDEADBEEF, 'h1004, 1);
      xp(2'b01, 32'h00000013, 'h1008, 0, 0, 0);
      send(32'h00000013, 'h1008, 0);
      xp(2'b01, 32'h4505FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
      send(32'h4505FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      xp(2'b01, 32'h00010001, 'h1100, 0, 0, 0);
`endif
      send(32'h00010001, 'h1100, 0);
      out_ready_i = 1'b0;
      fetch_valid_i = 1'b1; fetch_data_i = 32'h00A00093; fetch_addr_i = 'h1104;
      repeat (3) begin
         @(negedge clk_i);
         chk("stall_ready", 64'(fetch_ready_o), 64'h0);
         chk("stall_instr0", 64'(instr_o[0]), 64'(q[0].i0));
         chk("stall_addr0", addr_o[0], q[0].a0);
      end
      @(posedge clk_i); #1;
      out_ready_i = 1'b1;
      xp(2'b01, 32'h00A00093, 'h1104, 0, 0, 0);
      @(negedge clk_i);
      chk("release_ready", 64'(fetch_ready_o), 64'h1);
      @(posedge clk_i); #1;
      fetch_valid_i = 1'b0;
`ifdef FETCH_REALIGNER_RVC_EN
      xp(2'b01, 32'h1, 'h1F00, 0, 0, 0);
`else
      xp(2'b01, 32'h00930001, 'h1F00, 0, 0, 0);
`endif
      send(32'h00930001, 'h1F00, 0);
      flush_i = 1'b1;
      fetch_valid_i = 1'b1; fetch_data_i = 32'h00010001; fetch_addr_i = 'h3000;
      @(negedge clk_i);
      chk("flush_ready", 64'(fetch_ready_o), 64'h1);
      @(posedge clk_i); #1;
      flush_i = 1'b0; fetch_valid_i = 1'b0;
      @(negedge clk_i);
      chk("flush_valid", 64'(valid_o), 64'h0);
      chk("flush_ex", 64'(ex_o), 64'h0);
      @(posedge clk_i); #1;
      xp(2'b01, 32'h00000013, 'h2000, 0, 0, 0);
      send(32'h00000013, 'h2000, 0);
      idle(2);
      out_ready_i = 1'b0;
      send(32'h00930001, 'h4000, 0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0; out_ready_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_valid", 64'(valid_o), 64'h0);
      chk("midrst_instr0", 64'(instr_o[0]), 64'h0);
      @(posedge clk_i); #1;
      xp(2'b01, 32'h00A00093, 'h4004, 0, 0, 0);
      send(32'h00A00093, 'h4004, 0);
      idle(3);
      chk("queue_drained", 64'(q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
   task automatic idle(int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask
endmodule
